// File: rtl/bm_gauss_combiner.sv
// Box-Muller output stage: combines a magnitude f with a sin/cos pair into two
// signed Q4.11 Gaussian samples, x0 = f*sin and x1 = f*cos, via a 4-state handshake FSM.
module bm_gauss_combiner #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_valid,
    input  logic [15:0]          f_data,
    input  logic                 trig_valid,
    input  logic [15:0]          sin_data,
    input  logic [15:0]          cos_data,
    input  logic                 sign_sin,
    input  logic                 sign_cos,
    input  logic                 out_ready,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [15:0]          x0,
    output logic [15:0]          x1,
    output logic [CNT_WIDTH-1:0] sample_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_RND,
        S_OUT
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [15:0]            r_f;
    logic [15:0]            r_sin;
    logic [15:0]            r_cos;
    logic                   r_sign_sin;
    logic                   r_sign_cos;
    logic                   r_f_have;
    logic                   r_t_have;
    logic [31:0]            r_prod_s;
    logic [31:0]            r_prod_c;
    logic [15:0]            r_x0;
    logic [15:0]            r_x1;
    logic                   r_out_valid;
    logic [CNT_WIDTH-1:0]   r_count;

    logic                   w_pair_ready;

    // An operand counts as present if it is already held or arriving on this edge.
    assign w_pair_ready = (r_f_have | f_valid) & (r_t_have | trig_valid);

    // Round UQ3.29 to Q4.11 magnitude (33-bit sum keeps the carry of the
    // all-ones product, giving at most 0x4000), then apply the quadrant sign.
    function automatic logic [15:0] round_sign(input logic [31:0] prod, input logic neg);
        logic [32:0] sum;
        logic [15:0] mag;
        sum = {1'b0, prod} + 33'h0_0002_0000;
        mag = {1'b0, sum[32:18]};
        return neg ? (16'h0000 - mag) : mag;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves it
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_pair_ready) w_next_state = S_MUL;
            S_MUL:   w_next_state = S_RND;
            S_RND:   w_next_state = S_OUT;
            S_OUT:   if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f         <= '0;
            r_sin       <= '0;
            r_cos       <= '0;
            r_sign_sin  <= 1'b0;
            r_sign_cos  <= 1'b0;
            r_f_have    <= 1'b0;
            r_t_have    <= 1'b0;
            r_prod_s    <= '0;
            r_prod_c    <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Newest value wins while waiting for the other operand.
                    if (f_valid) begin
                        r_f      <= f_data;
                        r_f_have <= 1'b1;
                    end
                    if (trig_valid) begin
                        r_sin      <= sin_data;
                        r_cos      <= cos_data;
                        r_sign_sin <= sign_sin;
                        r_sign_cos <= sign_cos;
                        r_t_have   <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_prod_s <= {16'h0000, r_f} * {16'h0000, r_sin};
                    r_prod_c <= {16'h0000, r_f} * {16'h0000, r_cos};
                end
                S_RND: begin
                    r_x0        <= round_sign(r_prod_s, r_sign_sin);
                    r_x1        <= round_sign(r_prod_c, r_sign_cos);
                    r_out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_f_have    <= 1'b0;
                        r_t_have    <= 1'b0;
                        r_count     <= r_count + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = r_out_valid;
    assign x0           = r_x0;
    assign x1           = r_x1;
    assign sample_count = r_count;

endmodule

// File: doc/bm_gauss_combiner.md
BM_GAUSS_COMBINER -- requirements
Module: bm_gauss_combiner

Interface
REQ-001 Parameter CNT_WIDTH, default 32, width of sample_count.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 f_valid  input  1  magnitude sample valid (single-cycle or held).
REQ-005 f_data  input  16  magnitude sqrt(-2 ln u1), unsigned UQ3.13.
REQ-006 trig_valid  input  1  sin/cos pair valid (level, e.g. sin/cos unit done).
REQ-007 sin_data  input  16  |sin| magnitude, unsigned UQ0.16.
REQ-008 cos_data  input  16  |cos| magnitude, unsigned UQ0.16.
REQ-009 sign_sin  input  1  1 = negative sin quadrant.
REQ-010 sign_cos  input  1  1 = negative cos quadrant.
REQ-011 out_ready  input  1  downstream accepts x0/x1.
REQ-012 in_ready  output  1  block accepts inputs (high only in IDLE).
REQ-013 out_valid  output  1  x0/x1 hold a valid Gaussian pair.
REQ-014 x0  output  16  signed Q4.11 Gaussian sample, f*sin.
REQ-015 x1  output  16  signed Q4.11 Gaussian sample, f*cos.
REQ-016 sample_count  output  CNT_WIDTH  number of pairs handed off.

Function
REQ-017 FSM states IDLE, MUL, RND, OUT; reset state IDLE.
REQ-018 IDLE: in_ready=1; f_valid registers f_data, sets f_have; trig_valid registers sin/cos/signs, sets t_have; both may occur in the same cycle or in either order.
REQ-019 IDLE: repeated valid on an already-held operand overwrites it with the newest value.
REQ-020 IDLE->MUL on the edge at which f_have and t_have are both set (including the capture edge itself).
REQ-021 MUL (1 cycle): register prod_s = f*sin, prod_c = f*cos, 32-bit unsigned UQ3.29; ->RND.
REQ-022 RND (1 cycle): mag = (prod + 0x20000) >> 18, sum computed at 33 bits, mag 15 bits (max 0x4000, no saturation); x = sign ? -mag : mag in 16-bit two's complement; out_valid<=1; ->OUT.
REQ-023 mag = 0 yields x = 0x0000 regardless of sign.
REQ-024 Latency: out_valid high 2 cycles after the IDLE->MUL edge; minimum 4 cycles per pair.
REQ-025 OUT: x0, x1, out_valid stable while out_ready=0; inputs ignored.
REQ-026 OUT with out_ready=1: out_valid<=0, f_have/t_have cleared, sample_count+1, ->IDLE.
REQ-027 sample_count wraps from 2^CNT_WIDTH-1 to 0.
REQ-028 in_ready and out_valid never both 1.

Reset
REQ-029 On reset: state IDLE, in_ready=1, out_valid=0, x0=x1=0, sample_count=0, f_have=t_have=0, products 0.
REQ-030 Reset in any state discards pending operands and results; no partial output after release.

Verification
REQ-031 f=0x2000, sin=0x8000, cos=0xFFFF, sign_sin=0, sign_cos=1, same cycle, out_ready=1 -> x0=0x0400, x1=0xF800, out_valid 2 cycles after capture, count=1.
REQ-032 f=0xFFFF, sin=cos=0xFFFF, sign_sin=1, sign_cos=0 -> x0=0xC000, x1=0x4000 (33-bit rounding carry).
REQ-033 trig_valid first, f_valid 3 cycles later with sin=0 -> no MUL before f capture; x0=0x0000 with sign_sin=1.
REQ-034 out_ready low 5 cycles in OUT -> x0/x1 unchanged, in_ready=0, count increments exactly once on release.
REQ-035 reset asserted during MUL -> all outputs at reset values immediately; new pair after release processed normally.
REQ-036 CNT_WIDTH=4, 16 back-to-back pairs -> sample_count returns to 0.
